// File: rtl/fme_sched_pkg.sv
// ============================================================================
// fme_pkg : shared types and constants for the FME candidate scheduler
// Rev 1.0
// ============================================================================
`default_nettype none

package fme_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_HALF_ISSUE = 3'd1,
    S_HALF_WAIT  = 3'd2,
    S_QUAR_ISSUE = 3'd3,
    S_QUAR_WAIT  = 3'd4,
    S_REPORT     = 3'd5,
    S_DONE       = 3'd6
  } state_e;

  typedef enum logic {
    PH_HALF = 1'b0,
    PH_QUAR = 1'b1
  } phase_e;

  localparam logic [3:0] CAND_CTR   = 4'd0;
  localparam logic [3:0] CAND_FIRST = 4'd1;
  localparam logic [3:0] CAND_LAST  = 4'd8;

  localparam int NUM_HALF = 9;
  localparam int NUM_QUAR = 8;

endpackage

`default_nettype wire

// File: rtl/fme_sched_if.sv
// ============================================================================
// fme_sched_if : control, candidate and result bus of the FME scheduler
// Rev 1.0
// ============================================================================
`default_nettype none

interface fme_sched_if #(
  parameter int SAD_W = 16
);
  logic             start;
  logic [7:0]       pix_pos;
  logic             busy;
  logic             cand_valid;
  logic             cand_ready;
  logic [7:0]       cand_pos;
  logic [3:0]       cand_blk;
  logic             cand_phase;
  logic [3:0]       cand_idx;
  logic             sad_valid;
  logic [SAD_W-1:0] sad;
  logic             res_valid;
  logic [3:0]       res_blk;
  logic [3:0]       half_best;
  logic [3:0]       quat_best;
  logic [SAD_W-1:0] res_cost;
  logic             done;

  modport master (
    output start, pix_pos, cand_ready, sad_valid, sad,
    input  busy, cand_valid, cand_pos, cand_blk, cand_phase, cand_idx,
           res_valid, res_blk, half_best, quat_best, res_cost, done
  );

  modport slave (
    input  start, pix_pos, cand_ready, sad_valid, sad,
    output busy, cand_valid, cand_pos, cand_blk, cand_phase, cand_idx,
           res_valid, res_blk, half_best, quat_best, res_cost, done
  );
endinterface

`default_nettype wire

// File: rtl/fme_best_sel.sv
// ============================================================================
// fme_best_sel : running-minimum register; strict-less update keeps lower idx
// Rev 1.0
// ============================================================================
`default_nettype none

module fme_best_sel
  import fme_pkg::*;
#(
  parameter int SAD_W = 16
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_init,
  input  wire logic             i_upd,
  input  wire logic             i_rebase,
  input  wire logic [3:0]       i_idx,
  input  wire logic [SAD_W-1:0] i_cost,
  output logic      [3:0]       o_win_idx,
  output logic      [SAD_W-1:0] o_win_cost
);

  logic [3:0]       r_idx;
  logic [SAD_W-1:0] r_cost;
  logic             w_take;

  assign w_take     = i_init | (i_upd & (i_cost < r_cost));
  assign o_win_idx  = w_take ? i_idx  : r_idx;
  assign o_win_cost = w_take ? i_cost : r_cost;

  // Rebase keeps the winning cost but renames it as the centre of the next phase
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx  <= CAND_CTR;
      r_cost <= '0;
    end else begin
      r_idx  <= i_rebase ? CAND_CTR : o_win_idx;
      r_cost <= o_win_cost;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fme_sched.sv
// ============================================================================
// fme_sched : walks sub-blocks issuing 9 half-pel then 8 quarter-pel candidates
// Option macro FME_EARLY_TERM_EN: zero centre SAD ends the block search. Rev 1.0
// ============================================================================
`default_nettype none

module fme_sched
  import fme_pkg::*;
#(
  parameter int SAD_W   = 16,
  parameter int NUM_BLK = 16
) (
  input wire logic  clk,
  input wire logic  rst,
  fme_sched_if.slave bus
);

  state_e           r_state, w_next;
  logic [7:0]       r_pos;
  logic [3:0]       r_blk;
  phase_e           r_phase;
  logic [3:0]       r_idx;
  logic [3:0]       r_half_sel;
  logic [3:0]       r_half_best;
  logic [3:0]       r_quat_best;
  logic [3:0]       r_res_blk;
  logic [SAD_W-1:0] r_res_cost;

  logic             w_issue;
  logic             w_accept;
  logic             w_sad_half;
  logic             w_sad_quar;
  logic             w_last;
  logic             w_blk_last;
  logic             w_early;
  logic [3:0]       w_win_idx;
  logic [SAD_W-1:0] w_win_cost;

  assign w_issue    = (r_state == S_HALF_ISSUE) || (r_state == S_QUAR_ISSUE);
  assign w_accept   = w_issue && bus.cand_ready;
  assign w_sad_half = (r_state == S_HALF_WAIT) && bus.sad_valid;
  assign w_sad_quar = (r_state == S_QUAR_WAIT) && bus.sad_valid;
  assign w_last     = (r_idx == CAND_LAST);
  assign w_blk_last = (r_blk == 4'(NUM_BLK - 1));

`ifdef FME_EARLY_TERM_EN
  assign w_early = w_sad_half && (r_idx == CAND_CTR) && (bus.sad == '0);
`else
  assign w_early = 1'b0;
`endif

  fme_best_sel #(.SAD_W(SAD_W)) u_best (
    .clk        (clk),
    .rst        (rst),
    .i_init     (w_sad_half && (r_idx == CAND_CTR)),
    .i_upd      ((w_sad_half || w_sad_quar) && (r_idx != CAND_CTR)),
    .i_rebase   (w_sad_half && w_last),
    .i_idx      (r_idx),
    .i_cost     (bus.sad),
    .o_win_idx  (w_win_idx),
    .o_win_cost (w_win_cost)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:       if (bus.start) w_next = S_HALF_ISSUE;
      S_HALF_ISSUE: if (w_accept) w_next = S_HALF_WAIT;
      S_HALF_WAIT: begin
        if (w_early)         w_next = S_REPORT;
        else if (w_sad_half) w_next = w_last ? S_QUAR_ISSUE : S_HALF_ISSUE;
      end
      S_QUAR_ISSUE: if (w_accept) w_next = S_QUAR_WAIT;
      S_QUAR_WAIT:  if (w_sad_quar) w_next = w_last ? S_REPORT : S_QUAR_ISSUE;
      S_REPORT:     w_next = w_blk_last ? S_DONE : S_HALF_ISSUE;
      S_DONE:       w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pos       <= '0;
      r_blk       <= '0;
      r_phase     <= PH_HALF;
      r_idx       <= CAND_CTR;
      r_half_sel  <= CAND_CTR;
      r_half_best <= '0;
      r_quat_best <= '0;
      r_res_blk   <= '0;
      r_res_cost  <= '0;
    end else begin
      if ((r_state == S_IDLE) && bus.start) begin
        r_pos   <= bus.pix_pos;
        r_blk   <= '0;
        r_phase <= PH_HALF;
        r_idx   <= CAND_CTR;
      end
      if (w_early) begin
        r_half_best <= CAND_CTR;
        r_quat_best <= CAND_CTR;
        r_res_cost  <= '0;
        r_res_blk   <= r_blk;
      end else if (w_sad_half) begin
        if (w_last) begin
          r_half_sel <= w_win_idx;
          r_phase    <= PH_QUAR;
          r_idx      <= CAND_FIRST;
        end else begin
          r_idx <= r_idx + 4'd1;
        end
      end
      // Result registers only move on REPORT entry so they hold between pulses
      if (w_sad_quar) begin
        if (w_last) begin
          r_half_best <= r_half_sel;
          r_quat_best <= w_win_idx;
          r_res_cost  <= w_win_cost;
          r_res_blk   <= r_blk;
        end else begin
          r_idx <= r_idx + 4'd1;
        end
      end
      if (r_state == S_REPORT) begin
        r_phase <= PH_HALF;
        r_idx   <= CAND_CTR;
        if (!w_blk_last) r_blk <= r_blk + 4'd1;
      end
    end
  end

  assign bus.busy       = (r_state != S_IDLE);
  assign bus.cand_valid = w_issue;
  assign bus.cand_pos   = r_pos;
  assign bus.cand_blk   = r_blk;
  assign bus.cand_phase = r_phase;
  assign bus.cand_idx   = r_idx;
  assign bus.res_valid  = (r_state == S_REPORT);
  assign bus.res_blk    = r_res_blk;
  assign bus.half_best  = r_half_best;
  assign bus.quat_best  = r_quat_best;
  assign bus.res_cost   = r_res_cost;
  assign bus.done       = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_fme_sched.sv
// ============================================================================
// tb_fme_sched : scoreboard bench for fme_sched (honours FME_EARLY_TERM_EN)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fme_sched;
  import fme_pkg::*;

  localparam int SAD_W   = 16;
  localparam int NUM_BLK = 16;

  logic clk;
  logic rst;

  fme_sched_if #(.SAD_W(SAD_W)) bus ();

  fme_sched #(.SAD_W(SAD_W), .NUM_BLK(NUM_BLK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]       blk;
    logic [3:0]       hb;
    logic [3:0]       qb;
    logic [SAD_W-1:0] cost;
  } res_t;

  res_t             sbq[$];
  int               n_vec = 0;
  int               n_err = 0;
  int               ncyc = 0;
  int               mode = 0;
  int               stall_left = 0;
  bit               spur_en = 0;
  bit               pend = 0;
  bit               done_seen = 0;
  int               done_cyc = 0;
  logic [SAD_W-1:0] pend_sad;
  logic [7:0]       exp_pos;
  int               exp_blk, exp_ph, exp_idx;
  int               t_start;

  function automatic logic [SAD_W-1:0] sad_fn(int m, int b, int ph, int i);
    case (m)
      0: begin
        if (ph == 0 && i == 3) return 16'd40;
        if (ph == 1 && i == 6) return 16'd20;
        return 16'd100;
      end
      1:       return 16'd50;
      2:       return SAD_W'(((b * 7 + i * 13 + ph * 5) % 11) * 10 + 20);
      default: return (ph == 0 && i == 0) ? 16'd0 : 16'd100;
    endcase
  endfunction

  function automatic res_t model(int m, int b);
    res_t             r;
    logic [SAD_W-1:0] best, s;
    int               hb, qb;
    best = sad_fn(m, b, 0, 0);
    hb   = 0;
    qb   = 0;
    r.blk = 4'(b);
`ifdef FME_EARLY_TERM_EN
    if (best == 0) begin
      r.hb = 0; r.qb = 0; r.cost = 0;
      return r;
    end
`endif
    for (int i = 1; i <= 8; i++) begin
      s = sad_fn(m, b, 0, i);
      if (s < best) begin best = s; hb = i; end
    end
    for (int i = 1; i <= 8; i++) begin
      s = sad_fn(m, b, 1, i);
      if (s < best) begin best = s; qb = i; end
    end
    r.hb   = 4'(hb);
    r.qb   = 4'(qb);
    r.cost = best;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, ncyc);
    end
  endtask

  task automatic monitor();
    res_t e;
    if (bus.res_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        check("res_unexpected", 1, 0);
      end else begin
        e = sbq.pop_front();
        check("res_blk",   bus.res_blk,   e.blk);
        check("half_best", bus.half_best, e.hb);
        check("quat_best", bus.quat_best, e.qb);
        check("res_cost",  bus.res_cost,  e.cost);
      end
    end
    if (bus.done === 1'b1) begin
      check("busy_at_done", bus.busy, 1);
      done_seen = 1;
      done_cyc  = ncyc;
    end
  endtask

  task automatic respond();
    bit skip;
    skip = 0;
    bus.sad_valid = 1'b0;
    if (pend) begin
      bus.sad_valid  = 1'b1;
      bus.sad        = pend_sad;
      bus.cand_ready = 1'b1;
      pend = 0;
    end else if (spur_en && bus.cand_valid && exp_blk == 1 && exp_ph == 0 && exp_idx == 2) begin
      spur_en        = 0;
      bus.sad_valid  = 1'b1;
      bus.sad        = '0;
      bus.cand_ready = 1'b0;
    end else if (stall_left > 0 && bus.cand_valid && exp_blk == 2 && exp_ph == 0 && exp_idx == 4) begin
      stall_left--;
      bus.cand_ready = 1'b0;
      check("stall_idx", bus.cand_idx, exp_idx);
      check("stall_blk", bus.cand_blk, exp_blk);
      check("stall_pos", bus.cand_pos, exp_pos);
    end else begin
      bus.cand_ready = 1'b1;
    end

    if (bus.cand_valid === 1'b1 && bus.cand_ready === 1'b1) begin
      check("cand_pos",   bus.cand_pos,   exp_pos);
      check("cand_blk",   bus.cand_blk,   exp_blk);
      check("cand_phase", bus.cand_phase, exp_ph);
      check("cand_idx",   bus.cand_idx,   exp_idx);
      pend     = 1;
      pend_sad = sad_fn(mode, exp_blk, exp_ph, exp_idx);
`ifdef FME_EARLY_TERM_EN
      skip = (exp_ph == 0 && exp_idx == 0 && pend_sad == 0);
`endif
      if (skip || (exp_ph == 1 && exp_idx == 8)) begin
        exp_blk++; exp_ph = 0; exp_idx = 0;
      end else if (exp_ph == 0 && exp_idx == 8) begin
        exp_ph = 1; exp_idx = 1;
      end else begin
        exp_idx++;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    ncyc++;
    monitor();
    respond();
  endtask

  task automatic begin_mb(input int m, input logic [7:0] pos);
    mode      = m;
    exp_pos   = pos;
    exp_blk   = 0;
    exp_ph    = 0;
    exp_idx   = 0;
    done_seen = 0;
    for (int b = 0; b < NUM_BLK; b++) sbq.push_back(model(m, b));
    bus.start   = 1'b1;
    bus.pix_pos = pos;
    t_start     = ncyc;
    tick();
    bus.start   = 1'b0;
    bus.pix_pos = ~pos;
    check("busy_after_start", bus.busy, 1);
  endtask

  task automatic run_mb(input int m, input logic [7:0] pos, input int exp_lat);
    begin_mb(m, pos);
    for (int i = 0; i < 3000 && !done_seen; i++) begin
      tick();
      bus.start = (i == 100);
    end
    bus.start = 1'b0;
    if (!done_seen) check("done_timeout", 0, 1);
    else            check("done_latency", done_cyc - t_start, exp_lat);
    check("sb_left", sbq.size(), 0);
    tick();
    check("idle_busy", bus.busy, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},      bus.busy,       0);
    check({tag, "_cvalid"},    bus.cand_valid, 0);
    check({tag, "_res_valid"}, bus.res_valid,  0);
    check({tag, "_done"},      bus.done,       0);
    check({tag, "_cpos"},      bus.cand_pos,   0);
    check({tag, "_cblk"},      bus.cand_blk,   0);
    check({tag, "_cphase"},    bus.cand_phase, 0);
    check({tag, "_cidx"},      bus.cand_idx,   0);
    check({tag, "_hbest"},     bus.half_best,  0);
    check({tag, "_qbest"},     bus.quat_best,  0);
    check({tag, "_rblk"},      bus.res_blk,    0);
    check({tag, "_rcost"},     bus.res_cost,   0);
  endtask

  initial begin
    bit found;
    rst            = 1'b0;
    bus.start      = 1'b0;
    bus.pix_pos    = '0;
    bus.cand_ready = 1'b1;
    bus.sad_valid  = 1'b0;
    bus.sad        = '0;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b1;
    repeat (2) tick();

    run_mb(0, 8'h3c, 561);
    run_mb(1, 8'h81, 561);

    stall_left = 5;
    run_mb(2, 8'h5a, 566);
    check("stall_used", stall_left, 0);

    spur_en = 1;
    run_mb(2, 8'h17, 562);
    check("spur_used", spur_en, 0);

    // Reset in the middle of block 7
    begin_mb(0, 8'hc3);
    found = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      tick();
      found = (bus.cand_blk == 4'd7) && (bus.busy == 1'b1);
    end
    if (!found) check("blk7_timeout", 0, 1);
    rst = 1'b0;
    #1;
    check_all_zero("midrst");
    sbq.delete();
    pend          = 0;
    bus.sad_valid = 1'b0;
    done_seen     = 0;
    repeat (4) tick();
    rst = 1'b1;
    repeat (10) tick();
    check("no_done_after_rst", done_seen, 0);
    check("no_busy_after_rst", bus.busy, 0);
    run_mb(0, 8'h99, 561);

`ifdef FME_EARLY_TERM_EN
    run_mb(3, 8'h22, 49);
`else
    run_mb(3, 8'h22, 561);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
